multicycle_ctrl_fsm: RTL and testbench
======================================

# multicycle_ctrl_fsm

Multicycle MIPS control unit driving the shared-memory datapath. Consumes `op`, `funct` and `zero` from the datapath and produces every datapath select and enable, one instruction per 3–5 states. Moore FSM: all outputs are a function of the registered state, plus `op`, `funct` and `zero` in BRANCH. Sits beside the datapath inside the CPU top.

## Interface
**Parameters**
- `ST_W`, default 4: state register width; must stay ≥ 4.

**Ports**
- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `op` input 6: `Instr[31:26]`.
- `funct` input 6: `Instr[5:0]`.
- `zero` input 1: ALU zero flag, combinational.
- `PCen`, `IorD`, `Ori`, `MemWrite`, `IRWrite`, `RegWrite`, `ALUSrcA`, `ANDIsel` output 1 each: datapath enables and selects.
- `ALUSrcB`, `PCSrc`, `RegDst`, `MemtoReg` output 2 each: datapath mux selects.
- `ALUControl` output 3: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- `state_o` output ST_W: current state, for debug.

Mux encodings:
- ALUSrcB: 00 = regB, 01 = 4, 10 = sext(imm), 11 = sext(imm) << 2.
- PCSrc: 00 = ALUResult, 01 = ALU_o, 10 = jump target, 11 = rs.
- RegDst: 00 = rt, 01 = rd, 10 = 31.
- MemtoReg: 00 = ALU_o, 01 = MemOut, 10 = PC.

## Operation
**States:** FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, ALUWB_R=7, EXEC_I=8, ALUWB_I=9, BRANCH=10, JUMP=11, JAL=12, JR=13, GPIO_IN=14, GPIO_OUT=15.

**Default:** every output not listed for a state is 0.

- **FETCH:** IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00, PCen=1. Next state: DECODE.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ADD, so the branch target is captured in ALU_o. Next state by op:
  - 0x23/0x2B → MEMADR.
  - 0x00 → EXEC_R, except funct 0x08 → JR.
  - 0x08/0x0C/0x0D/0x0A → EXEC_I.
  - 0x04 → BRANCH.
  - 0x02 → JUMP.
  - 0x03 → JAL.
  - 0x3F → GPIO_IN.
  - 0x3E → GPIO_OUT.
  - Anything else, including unsupported R-type funct → FETCH with no write.
- **MEMADR / MEMRD / MEMWB / MEMWR:** all hold ALUSrcA=1, ALUSrcB=10, ADD, so ALU_o stays stable.
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD: IorD=1 → MEMWB.
  - MEMWB: IorD=1, RegDst=00, MemtoReg=01, RegWrite=1 → FETCH.
  - MEMWR: IorD=1, MemWrite=1 → FETCH.
- **EXEC_R:** ALUSrcA=1, ALUSrcB=00, ALUControl from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Next: ALUWB_R.
- **ALUWB_R:** RegDst=01, MemtoReg=00, RegWrite=1. Next: FETCH.
- **EXEC_I:** ALUSrcA=1, ALUSrcB=10, ALUControl from op: addi ADD, andi AND, ori OR, slti SLT. Next: ALUWB_I.
- **ALUWB_I:** RegDst=00, MemtoReg=00, RegWrite=1. Next: FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, PCen=zero. Next: FETCH.
- **JUMP:** PCSrc=10, PCen=1. Next: FETCH.
- **JAL:** PCSrc=10, PCen=1, RegDst=10, MemtoReg=10, RegWrite=1, so $31 receives PC+4 on the same edge the PC updates. Next: FETCH.
- **JR:** PCSrc=11, PCen=1, ANDIsel=0. Next: FETCH.
- **GPIO_IN:** Ori=1, ALUSrcA=1, ALUSrcB=10, ADD, giving rt ← rs + sext(GPIO_i). Next: ALUWB_I.
- **GPIO_OUT:** ANDIsel=1 for exactly one cycle; the GPIO wrapper latches rs. Next: FETCH.

## Timing
- **Reset:** while `reset`=1 at a clk edge, the state becomes FETCH. While `reset` is high, all outputs are forced to 0 and `state_o`=0. The first cycle after deassertion is FETCH with its normal outputs.
- **Reset mid-instruction:** aborts it. No RegWrite or MemWrite is asserted in the reset cycle or the cycle that follows.
- **Latency in cycles:**
  - lw: 5.
  - sw, R-type, I-type, GPIO_IN: 4.
  - beq, bne, j, jal, jr, GPIO_OUT, illegal: 3.
- **`zero` sampling:** used only in BRANCH, combinationally, in the same cycle.
- **Write enables:** RegWrite, MemWrite and IRWrite are single-cycle pulses; none is ever high in two consecutive cycles.

## Configuration
- `CTRL_BNE_EN` defined: op 0x05 decodes to BRANCH with PCen = ~zero.
- Undefined: op 0x05 is illegal (DECODE → FETCH, no write, PC already advanced by 4).
- beq is unaffected either way.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset. First post-reset cycle: state_o=0, PCen=1, IRWrite=1, ALUSrcB=01.
- lw (op 0x23) → state_o sequence 0,1,2,3,4,0. RegWrite=1 only in state 4, with MemtoReg=01, IorD=1.
- R-type op 0, funct 0x22 → EXEC_R drives ALUControl=110. ALUWB_R drives RegDst=01, RegWrite=1. Next cycle is FETCH.
- beq with zero=0 → BRANCH PCen=0. Repeat with zero=1 → PCen=1, PCSrc=01. With `CTRL_BNE_EN`, op 0x05 inverts both results; without it, op 0x05 gives state_o 0,1,0.
- jal (op 0x03) → JAL state with PCen=1, PCSrc=10, RegDst=10, MemtoReg=10, RegWrite=1. jr (op 0, funct 0x08) → PCSrc=11.
- GPIO_OUT (op 0x3E) → ANDIsel high for exactly 1 cycle. `reset` asserted during MEMWR → MemWrite=0 that cycle, state_o=0 next.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multicycle control FSM and the MIPS datapath.
// Carries the instruction fields and zero flag in, and every datapath select and enable out.
// master = control unit (drives selects), slave = datapath (drives op/funct/zero).
interface multicycle_ctrl_fsm_if #(
  parameter int ST_W = 4
);
  logic [5:0]      op;
  logic [5:0]      funct;
  logic            zero;
  logic            PCen;
  logic            IorD;
  logic            Ori;
  logic            MemWrite;
  logic            IRWrite;
  logic            RegWrite;
  logic            ALUSrcA;
  logic            ANDIsel;
  logic [1:0]      ALUSrcB;
  logic [1:0]      PCSrc;
  logic [1:0]      RegDst;
  logic [1:0]      MemtoReg;
  logic [2:0]      ALUControl;
  logic [ST_W-1:0] state_o;

  modport master (
    input  op, funct, zero,
    output PCen, IorD, Ori, MemWrite, IRWrite, RegWrite, ALUSrcA, ANDIsel,
           ALUSrcB, PCSrc, RegDst, MemtoReg, ALUControl, state_o
  );

  modport slave (
    output op, funct, zero,
    input  PCen, IorD, Ori, MemWrite, IRWrite, RegWrite, ALUSrcA, ANDIsel,
           ALUSrcB, PCSrc, RegDst, MemtoReg, ALUControl, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control FSM: decodes op/funct into datapath selects/enables, 3-5 states per instruction.
// Latency: outputs registered with the state; PCen in BRANCH also follows zero combinationally.
// No backpressure: advances one state per clock; synchronous reset forces all outputs to 0.
// Optional feature macro: CTRL_BNE_EN (op 0x05 decodes to BRANCH with PCen = ~zero).
module multicycle_ctrl_fsm #(
  parameter int ST_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXEC_R   = 4'd6,
    ALUWB_R  = 4'd7,
    EXEC_I   = 4'd8,
    ALUWB_I  = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12,
    JR       = 4'd13,
    GPIO_IN  = 4'd14,
    GPIO_OUT = 4'd15
  } state_t;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       ori;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       andisel;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [2:0] aluctl;
  } ctrl_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;
  logic   br_take;

  // R-type functions the datapath can execute; anything else is dropped in DECODE.
  function automatic logic rfunct_ok(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
  endfunction

  function automatic logic [2:0] alu_from_funct(input logic [5:0] f);
    case (f)
      6'h22:   return ALU_SUB;
      6'h24:   return ALU_AND;
      6'h25:   return ALU_OR;
      6'h2A:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] alu_from_op(input logic [5:0] o);
    case (o)
      6'h0C:   return ALU_AND;
      6'h0D:   return ALU_OR;
      6'h0A:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Output pattern of a state. op/funct are stable from DECODE onward because the
  // IR only loads in FETCH, so they can be folded into the registered outputs.
  function automatic ctrl_t outs_for(input state_t s, input logic [5:0] o, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite = 1'b1;
        c.alusrcb = 2'b01;
        c.aluctl  = ALU_ADD;
        c.pcen    = 1'b1;
      end
      DECODE: begin
        c.alusrcb = 2'b11;
        c.aluctl  = ALU_ADD;
      end
      MEMADR, MEMRD, MEMWB, MEMWR: begin
        // Address computation is held across the whole access so ALU_o never moves.
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluctl  = ALU_ADD;
        c.iord     = (s != MEMADR);
        c.regwrite = (s == MEMWB);
        c.memtoreg = (s == MEMWB) ? 2'b01 : 2'b00;
        c.memwrite = (s == MEMWR);
      end
      EXEC_R: begin
        c.alusrca = 1'b1;
        c.aluctl  = alu_from_funct(f);
      end
      ALUWB_R: begin
        c.regdst   = 2'b01;
        c.regwrite = 1'b1;
      end
      EXEC_I: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluctl  = alu_from_op(o);
      end
      ALUWB_I: begin
        c.regwrite = 1'b1;
      end
      BRANCH: begin
        // PCen is added combinationally from zero at the output.
        c.alusrca = 1'b1;
        c.aluctl  = ALU_SUB;
        c.pcsrc   = 2'b01;
      end
      JUMP: begin
        c.pcsrc = 2'b10;
        c.pcen  = 1'b1;
      end
      JAL: begin
        // $31 takes PC+4 on the same edge the PC jumps.
        c.pcsrc    = 2'b10;
        c.pcen     = 1'b1;
        c.regdst   = 2'b10;
        c.memtoreg = 2'b10;
        c.regwrite = 1'b1;
      end
      JR: begin
        c.pcsrc = 2'b11;
        c.pcen  = 1'b1;
      end
      GPIO_IN: begin
        c.ori     = 1'b1;
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluctl  = ALU_ADD;
      end
      GPIO_OUT: begin
        c.andisel = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection; DECODE dispatches on op (and funct for R-type).
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH: nxt = DECODE;
      DECODE: begin
        case (bus.op)
          6'h23, 6'h2B:               nxt = MEMADR;
          6'h00: begin
            if (bus.funct == 6'h08)          nxt = JR;
            else if (rfunct_ok(bus.funct))   nxt = EXEC_R;
            else                             nxt = FETCH;
          end
          6'h08, 6'h0C, 6'h0D, 6'h0A: nxt = EXEC_I;
          6'h04:                      nxt = BRANCH;
`ifdef CTRL_BNE_EN
          6'h05:                      nxt = BRANCH;
`endif
          6'h02:                      nxt = JUMP;
          6'h03:                      nxt = JAL;
          6'h3F:                      nxt = GPIO_IN;
          6'h3E:                      nxt = GPIO_OUT;
          default:                    nxt = FETCH;
        endcase
      end
      MEMADR:  nxt = (bus.op == 6'h2B) ? MEMWR : MEMRD;
      MEMRD:   nxt = MEMWB;
      EXEC_R:  nxt = ALUWB_R;
      EXEC_I:  nxt = ALUWB_I;
      GPIO_IN: nxt = ALUWB_I;
      default: nxt = FETCH;
    endcase
  end

  // State register with outputs registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctrl  <= outs_for(FETCH, bus.op, bus.funct);
    end else begin
      state <= nxt;
      ctrl  <= outs_for(nxt, bus.op, bus.funct);
    end
  end

  // Branch condition, evaluated in the BRANCH cycle itself.
  always_comb begin
`ifdef CTRL_BNE_EN
    br_take = (bus.op == 6'h05) ? ~bus.zero : bus.zero;
`else
    br_take = bus.zero;
`endif
  end

  // While reset is high every output is held at zero, so an aborted write never fires.
  assign bus.PCen       = ~reset & (ctrl.pcen | ((state == BRANCH) & br_take));
  assign bus.IorD       = ~reset & ctrl.iord;
  assign bus.Ori        = ~reset & ctrl.ori;
  assign bus.MemWrite   = ~reset & ctrl.memwrite;
  assign bus.IRWrite    = ~reset & ctrl.irwrite;
  assign bus.RegWrite   = ~reset & ctrl.regwrite;
  assign bus.ALUSrcA    = ~reset & ctrl.alusrca;
  assign bus.ANDIsel    = ~reset & ctrl.andisel;
  assign bus.ALUSrcB    = reset ? 2'b00 : ctrl.alusrcb;
  assign bus.PCSrc      = reset ? 2'b00 : ctrl.pcsrc;
  assign bus.RegDst     = reset ? 2'b00 : ctrl.regdst;
  assign bus.MemtoReg   = reset ? 2'b00 : ctrl.memtoreg;
  assign bus.ALUControl = reset ? 3'b000 : ctrl.aluctl;
  assign bus.state_o    = reset ? '0 : ST_W'(state);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-cycle vector table plus hand sequences.
// Each table row gives one cycle's inputs and the expected state and output word.
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.ST_W(4)) bus ();

  multicycle_ctrl_fsm #(.ST_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Output word: {PCen,IorD,Ori,MemWrite,IRWrite,RegWrite,ALUSrcA,ANDIsel,
  //               ALUSrcB,PCSrc,RegDst,MemtoReg,ALUControl}
  localparam logic [18:0] E_ZERO   = 19'd0;
  localparam logic [18:0] E_FETCH  = {8'b1000_1000, 8'b01_00_00_00, 3'b010};
  localparam logic [18:0] E_DECODE = {8'b0000_0000, 8'b11_00_00_00, 3'b010};
  localparam logic [18:0] E_MEMADR = {8'b0000_0010, 8'b10_00_00_00, 3'b010};
  localparam logic [18:0] E_MEMRD  = {8'b0100_0010, 8'b10_00_00_00, 3'b010};
  localparam logic [18:0] E_MEMWB  = {8'b0100_0110, 8'b10_00_00_01, 3'b010};
  localparam logic [18:0] E_MEMWR  = {8'b0101_0010, 8'b10_00_00_00, 3'b010};
  localparam logic [18:0] E_EXR_SB = {8'b0000_0010, 8'b00_00_00_00, 3'b110};
  localparam logic [18:0] E_EXR_SL = {8'b0000_0010, 8'b00_00_00_00, 3'b111};
  localparam logic [18:0] E_WB_R   = {8'b0000_0100, 8'b00_00_01_00, 3'b000};
  localparam logic [18:0] E_EXI_OR = {8'b0000_0010, 8'b10_00_00_00, 3'b001};
  localparam logic [18:0] E_EXI_AN = {8'b0000_0010, 8'b10_00_00_00, 3'b000};
  localparam logic [18:0] E_WB_I   = {8'b0000_0100, 8'b00_00_00_00, 3'b000};
  localparam logic [18:0] E_BR_T   = {8'b1000_0010, 8'b00_01_00_00, 3'b110};
  localparam logic [18:0] E_BR_N   = {8'b0000_0010, 8'b00_01_00_00, 3'b110};
  localparam logic [18:0] E_JUMP   = {8'b1000_0000, 8'b00_10_00_00, 3'b000};
  localparam logic [18:0] E_JAL    = {8'b1000_0100, 8'b00_10_10_10, 3'b000};
  localparam logic [18:0] E_JR     = {8'b1000_0000, 8'b00_11_00_00, 3'b000};
  localparam logic [18:0] E_GIN    = {8'b0010_0010, 8'b10_00_00_00, 3'b010};
  localparam logic [18:0] E_GOUT   = {8'b0000_0001, 8'b00_00_00_00, 3'b000};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  exp_st;
    logic [18:0] exp_o;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic [3:0] s, input logic [18:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.exp_st = s; v.exp_o = e;
    vecs.push_back(v);
  endtask

  function automatic logic [18:0] got_o();
    return {bus.PCen, bus.IorD, bus.Ori, bus.MemWrite, bus.IRWrite, bus.RegWrite,
            bus.ALUSrcA, bus.ANDIsel, bus.ALUSrcB, bus.PCSrc, bus.RegDst,
            bus.MemtoReg, bus.ALUControl};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z);
    reset = r; bus.op = o; bus.funct = f; bus.zero = z;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 6'h00, 6'h00, 1'b0);

    // Reset held three cycles, outputs forced low.
    for (int i = 0; i < 3; i++) add(1, 6'h00, 6'h00, 0, 4'd0, E_ZERO);
    // lw: 0,1,2,3,4
    add(0, 6'h23, 6'h00, 0, 4'd0, E_FETCH);
    add(0, 6'h23, 6'h00, 0, 4'd1, E_DECODE);
    add(0, 6'h23, 6'h00, 0, 4'd2, E_MEMADR);
    add(0, 6'h23, 6'h00, 0, 4'd3, E_MEMRD);
    add(0, 6'h23, 6'h00, 0, 4'd4, E_MEMWB);
    // sw: 0,1,2,5
    add(0, 6'h2B, 6'h00, 0, 4'd0, E_FETCH);
    add(0, 6'h2B, 6'h00, 0, 4'd1, E_DECODE);
    add(0, 6'h2B, 6'h00, 0, 4'd2, E_MEMADR);
    add(0, 6'h2B, 6'h00, 0, 4'd5, E_MEMWR);
    // sub: 0,1,6,7
    add(0, 6'h00, 6'h22, 0, 4'd0, E_FETCH);
    add(0, 6'h00, 6'h22, 0, 4'd1, E_DECODE);
    add(0, 6'h00, 6'h22, 0, 4'd6, E_EXR_SB);
    add(0, 6'h00, 6'h22, 0, 4'd7, E_WB_R);
    // slt: ALUControl 111
    add(0, 6'h00, 6'h2A, 0, 4'd0, E_FETCH);
    add(0, 6'h00, 6'h2A, 0, 4'd1, E_DECODE);
    add(0, 6'h00, 6'h2A, 0, 4'd6, E_EXR_SL);
    add(0, 6'h00, 6'h2A, 0, 4'd7, E_WB_R);
    // ori and andi
    add(0, 6'h0D, 6'h00, 0, 4'd0, E_FETCH);
    add(0, 6'h0D, 6'h00, 0, 4'd1, E_DECODE);
    add(0, 6'h0D, 6'h00, 0, 4'd8, E_EXI_OR);
    add(0, 6'h0D, 6'h00, 0, 4'd9, E_WB_I);
    add(0, 6'h0C, 6'h00, 0, 4'd0, E_FETCH);
    add(0, 6'h0C, 6'h00, 0, 4'd1, E_DECODE);
    add(0, 6'h0C, 6'h00, 0, 4'd8, E_EXI_AN);
    add(0, 6'h0C, 6'h00, 0, 4'd9, E_WB_I);
    // beq not taken, then taken (zero high throughout, ignored outside BRANCH)
    add(0, 6'h04, 6'h00, 0, 4'd0, E_FETCH);
    add(0, 6'h04, 6'h00, 0, 4'd1, E_DECODE);
    add(0, 6'h04, 6'h00, 0, 4'd10, E_BR_N);
    add(0, 6'h04, 6'h00, 1, 4'd0, E_FETCH);
    add(0, 6'h04, 6'h00, 1, 4'd1, E_DECODE);
    add(0, 6'h04, 6'h00, 1, 4'd10, E_BR_T);
    // bne
    add(0, 6'h05, 6'h00, 0, 4'd0, E_FETCH);
    add(0, 6'h05, 6'h00, 0, 4'd1, E_DECODE);
`ifdef CTRL_BNE_EN
    add(0, 6'h05, 6'h00, 0, 4'd10, E_BR_T);
    add(0, 6'h05, 6'h00, 1, 4'd0, E_FETCH);
    add(0, 6'h05, 6'h00, 1, 4'd1, E_DECODE);
    add(0, 6'h05, 6'h00, 1, 4'd10, E_BR_N);
`endif
    // j, jal, jr
    add(0, 6'h02, 6'h00, 0, 4'd0, E_FETCH);
    add(0, 6'h02, 6'h00, 0, 4'd1, E_DECODE);
    add(0, 6'h02, 6'h00, 0, 4'd11, E_JUMP);
    add(0, 6'h03, 6'h00, 0, 4'd0, E_FETCH);
    add(0, 6'h03, 6'h00, 0, 4'd1, E_DECODE);
    add(0, 6'h03, 6'h00, 0, 4'd12, E_JAL);
    add(0, 6'h00, 6'h08, 0, 4'd0, E_FETCH);
    add(0, 6'h00, 6'h08, 0, 4'd1, E_DECODE);
    add(0, 6'h00, 6'h08, 0, 4'd13, E_JR);
    // GPIO in: 0,1,14,9 ; GPIO out: 0,1,15 then back to FETCH
    add(0, 6'h3F, 6'h00, 0, 4'd0, E_FETCH);
    add(0, 6'h3F, 6'h00, 0, 4'd1, E_DECODE);
    add(0, 6'h3F, 6'h00, 0, 4'd14, E_GIN);
    add(0, 6'h3F, 6'h00, 0, 4'd9, E_WB_I);
    add(0, 6'h3E, 6'h00, 0, 4'd0, E_FETCH);
    add(0, 6'h3E, 6'h00, 0, 4'd1, E_DECODE);
    add(0, 6'h3E, 6'h00, 0, 4'd15, E_GOUT);
    add(0, 6'h3E, 6'h00, 0, 4'd0, E_FETCH);
    // ANDIsel gone after one cycle; illegal op 0x10
    add(0, 6'h10, 6'h00, 0, 4'd1, E_DECODE);
    // illegal R-type funct 0x21
    add(0, 6'h00, 6'h21, 0, 4'd0, E_FETCH);
    add(0, 6'h00, 6'h21, 0, 4'd1, E_DECODE);
    // reset during MEMWR aborts the store
    add(0, 6'h2B, 6'h00, 0, 4'd0, E_FETCH);
    add(0, 6'h2B, 6'h00, 0, 4'd1, E_DECODE);
    add(0, 6'h2B, 6'h00, 0, 4'd2, E_MEMADR);
    add(1, 6'h2B, 6'h00, 0, 4'd0, E_ZERO);
    add(0, 6'h2B, 6'h00, 0, 4'd0, E_FETCH);
    add(0, 6'h2B, 6'h00, 0, 4'd1, E_DECODE);
    add(0, 6'h2B, 6'h00, 0, 4'd2, E_MEMADR);
    add(0, 6'h2B, 6'h00, 0, 4'd5, E_MEMWR);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero);
      @(negedge clk);
      check($sformatf("row%0d state_o", i), 32'(bus.state_o), 32'(vecs[i].exp_st));
      check($sformatf("row%0d outputs", i), 32'(got_o()), 32'(vecs[i].exp_o));
      next_cycle();
    end

    // zero is combinational inside BRANCH: toggle it mid-cycle.
    drive(1'b0, 6'h04, 6'h00, 1'b0);
    @(negedge clk);
    check("beq_fetch state_o", 32'(bus.state_o), 32'd0);
    next_cycle();
    @(negedge clk);
    check("beq_decode state_o", 32'(bus.state_o), 32'd1);
    next_cycle();
    @(negedge clk);
    check("beq_branch state_o", 32'(bus.state_o), 32'd10);
    check("beq zero0 PCen", 32'(bus.PCen), 32'd0);
    bus.zero = 1'b1;
    #1;
    check("beq zero1 PCen", 32'(bus.PCen), 32'd1);
    check("beq zero1 PCSrc", 32'(bus.PCSrc), 32'd1);
    next_cycle();
    bus.zero = 1'b0;
    @(negedge clk);
    check("beq_after state_o", 32'(bus.state_o), 32'd0);

    // Reset asserted mid-cycle in MEMWR drops MemWrite at once.
    drive(1'b0, 6'h2B, 6'h00, 1'b0);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("sw MEMWR state_o", 32'(bus.state_o), 32'd5);
    check("sw MEMWR MemWrite", 32'(bus.MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    check("rst MemWrite", 32'(bus.MemWrite), 32'd0);
    check("rst state_o", 32'(bus.state_o), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("post-rst state_o", 32'(bus.state_o), 32'd0);
    check("post-rst RegWrite", 32'(bus.RegWrite), 32'd0);
    check("post-rst MemWrite", 32'(bus.MemWrite), 32'd0);
    check("post-rst IRWrite", 32'(bus.IRWrite), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
